// File: rtl/pc_fetch_stage.sv
// Fetch stage: owns the PC, drives instruction memory and loads the fetch/decode
// register. Includes a BOOT/RUN/HALT sequencer and a saturating issue counter.
module pc_fetch_stage #(
  parameter int                 WIDTH     = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [WIDTH-1:0]   RESET_PC  = '0,
  parameter int                 PC_STEP   = 4,
  parameter logic [INSTR_W-1:0] HALT_WORD = '1
) (
  input  logic               clk,
  input  logic               reset,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_f,
  input  logic               flush_d,
  input  logic               branch_taken,
  input  logic [WIDTH-1:0]   branch_target,
  output logic [INSTR_W-1:0] instr_d,
  output logic [WIDTH-1:0]   pc_d,
  output logic [WIDTH-1:0]   pc_step_d,
  output logic               valid_d,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] pc_f, pc_nx, pc_inc;
  logic             clr, load, bubble;

  assign pc_inc    = pc_f + STEP;
  assign imem_addr = pc_f;
  assign halted    = (state == HALT);

  always_comb begin
    state_nx = state;
    pc_nx    = pc_f;
    clr      = 1'b0;
    load     = 1'b0;
    bubble   = 1'b0;
    unique case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        if (branch_taken) begin
          pc_nx = branch_target;
          clr   = 1'b1;
        end else if (stall_f) begin
          clr = flush_d;
        end else begin
          // A halt word is still issued; only the PC advance is suppressed.
          if (imem_rdata == HALT_WORD) state_nx = HALT;
          else                         pc_nx    = pc_inc;
          clr  = flush_d;
          load = !flush_d;
        end
      end
      HALT: begin
        if (branch_taken) begin
          pc_nx    = branch_target;
          clr      = 1'b1;
          state_nx = RUN;
        end else if (flush_d) begin
          clr = 1'b1;
        end else begin
          bubble = !stall_f;
        end
      end
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
      pc_f  <= RESET_PC;
    end else begin
      state <= state_nx;
      pc_f  <= pc_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_d   <= '0;
      pc_d      <= '0;
      pc_step_d <= '0;
      valid_d   <= 1'b0;
    end else if (clr) begin
      instr_d   <= '0;
      pc_d      <= '0;
      pc_step_d <= '0;
      valid_d   <= 1'b0;
    end else if (load) begin
      instr_d   <= imem_rdata;
      pc_d      <= pc_f;
      pc_step_d <= pc_inc;
      valid_d   <= 1'b1;
    end else if (bubble) begin
      valid_d   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               fetch_count <= '0;
    else if (load && (fetch_count != 16'hFFFF)) fetch_count <= fetch_count + 16'd1;
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed vector table, randomized run against a
// behavioural model, and hand sequences for wrap, saturation and async reset.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_rdata, branch_target;
  logic        stall_f, flush_d, branch_taken;
  logic [31:0] instr_d, pc_d, pc_step_d;
  logic        valid_d, halted;
  logic [15:0] fetch_count;

  logic        reset8;
  logic [7:0]  a8, tgt8, pcd8, step8;
  logic [31:0] r8, instr8;
  logic        br8, valid8, halted8;
  logic [15:0] count8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h20) ? 32'hFFFFFFFF : 32'h1000 + a;
  endfunction

  assign imem_rdata = mem(imem_addr);
  assign r8         = 32'h1000 + {24'h0, a8};

  pc_fetch_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall_f(stall_f), .flush_d(flush_d), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr_d(instr_d), .pc_d(pc_d),
    .pc_step_d(pc_step_d), .valid_d(valid_d), .halted(halted),
    .fetch_count(fetch_count)
  );

  pc_fetch_stage #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .imem_addr(a8), .imem_rdata(r8),
    .stall_f(1'b0), .flush_d(1'b0), .branch_taken(br8),
    .branch_target(tgt8), .instr_d(instr8), .pc_d(pcd8),
    .pc_step_d(step8), .valid_d(valid8), .halted(halted8),
    .fetch_count(count8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        stall, flush, br;
    logic [31:0] target;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr, e_pcd, e_step;
    logic        e_halted;
    logic [15:0] e_count;
    logic        chk_data;
  } vec_t;

  vec_t vt[17];

  // Reference model: fetch semantics stated directly in terms of the rules.
  int          m_mode;   // 0 boot, 1 run, 2 halted
  logic [31:0] m_pc, m_instr, m_pcd, m_step;
  logic        m_valid;
  int          m_count;

  task automatic m_clear();
    m_instr = 0; m_pcd = 0; m_step = 0; m_valid = 0;
  endtask

  task automatic model_edge(input logic st, input logic fl, input logic br, input logic [31:0] tg);
    logic [31:0] word;
    word = mem(m_pc);
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (br) begin
      m_pc = tg; m_clear(); m_mode = 1;
    end else if (m_mode == 2) begin
      if (fl) m_clear();
      else if (!st) m_valid = 0;
    end else if (st) begin
      if (fl) m_clear();
    end else begin
      if (fl) m_clear();
      else begin
        m_instr = word; m_pcd = m_pc; m_step = m_pc + 4; m_valid = 1;
        if (m_count < 65535) m_count++;
      end
      if (word == 32'hFFFFFFFF) m_mode = 2;
      else m_pc = m_pc + 4;
    end
  endtask

  initial begin
    vt[0]  = '{1'b0,1'b0,1'b1,32'h99, 32'h00,1'b0,32'h0,32'h0,32'h0,1'b0,16'd0,1'b1};
    vt[1]  = '{1'b0,1'b0,1'b0,32'h0,  32'h04,1'b1,32'h1000,32'h0,32'h4,1'b0,16'd1,1'b1};
    vt[2]  = '{1'b0,1'b0,1'b0,32'h0,  32'h08,1'b1,32'h1004,32'h4,32'h8,1'b0,16'd2,1'b1};
    vt[3]  = '{1'b1,1'b0,1'b0,32'h0,  32'h08,1'b1,32'h1004,32'h4,32'h8,1'b0,16'd2,1'b1};
    vt[4]  = '{1'b1,1'b0,1'b0,32'h0,  32'h08,1'b1,32'h1004,32'h4,32'h8,1'b0,16'd2,1'b1};
    vt[5]  = '{1'b1,1'b0,1'b0,32'h0,  32'h08,1'b1,32'h1004,32'h4,32'h8,1'b0,16'd2,1'b1};
    vt[6]  = '{1'b1,1'b1,1'b0,32'h0,  32'h08,1'b0,32'h0,32'h0,32'h0,1'b0,16'd2,1'b1};
    vt[7]  = '{1'b0,1'b0,1'b0,32'h0,  32'h0C,1'b1,32'h1008,32'h8,32'hC,1'b0,16'd3,1'b1};
    vt[8]  = '{1'b0,1'b0,1'b0,32'h0,  32'h10,1'b1,32'h100C,32'hC,32'h10,1'b0,16'd4,1'b1};
    vt[9]  = '{1'b1,1'b0,1'b1,32'h40, 32'h40,1'b0,32'h0,32'h0,32'h0,1'b0,16'd4,1'b1};
    vt[10] = '{1'b0,1'b0,1'b0,32'h0,  32'h44,1'b1,32'h1040,32'h40,32'h44,1'b0,16'd5,1'b1};
    vt[11] = '{1'b0,1'b0,1'b1,32'h20, 32'h20,1'b0,32'h0,32'h0,32'h0,1'b0,16'd5,1'b1};
    vt[12] = '{1'b0,1'b0,1'b0,32'h0,  32'h20,1'b1,32'hFFFFFFFF,32'h20,32'h24,1'b1,16'd6,1'b1};
    vt[13] = '{1'b0,1'b0,1'b0,32'h0,  32'h20,1'b0,32'h0,32'h0,32'h0,1'b1,16'd6,1'b0};
    vt[14] = '{1'b0,1'b0,1'b0,32'h0,  32'h20,1'b0,32'h0,32'h0,32'h0,1'b1,16'd6,1'b0};
    vt[15] = '{1'b0,1'b0,1'b1,32'h80, 32'h80,1'b0,32'h0,32'h0,32'h0,1'b0,16'd6,1'b1};
    vt[16] = '{1'b0,1'b0,1'b0,32'h0,  32'h84,1'b1,32'h1080,32'h80,32'h84,1'b0,16'd7,1'b1};

    reset = 1'b0; reset8 = 1'b0;
    stall_f = 1'b0; flush_d = 1'b0; branch_taken = 1'b0; branch_target = '0;
    br8 = 1'b0; tgt8 = '0;
    repeat (2) edge_step();
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", valid_d, 1'b0);
    chk("rst_instr", instr_d, 32'h0);
    chk("rst_pcd",   pc_d, 32'h0);
    chk("rst_step",  pc_step_d, 32'h0);
    chk("rst_halt",  halted, 1'b0);
    chk("rst_count", fetch_count, 16'h0);
    reset = 1'b1; reset8 = 1'b1;
    chk("boot_addr", imem_addr, 32'h0);

    for (int i = 0; i < 17; i++) begin
      stall_f = vt[i].stall; flush_d = vt[i].flush;
      branch_taken = vt[i].br; branch_target = vt[i].target;
      edge_step();
      chk($sformatf("vec%0d_pc", i),    imem_addr, vt[i].e_pc);
      chk($sformatf("vec%0d_valid", i), valid_d, vt[i].e_valid);
      chk($sformatf("vec%0d_halt", i),  halted, vt[i].e_halted);
      chk($sformatf("vec%0d_count", i), fetch_count, vt[i].e_count);
      if (vt[i].chk_data) begin
        chk($sformatf("vec%0d_instr", i), instr_d, vt[i].e_instr);
        chk($sformatf("vec%0d_pcd", i),   pc_d, vt[i].e_pcd);
        chk($sformatf("vec%0d_step", i),  pc_step_d, vt[i].e_step);
      end
    end

    // Asynchronous reset between edges while running.
    stall_f = 1'b0; flush_d = 1'b0; branch_taken = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_addr",  imem_addr, 32'h0);
    chk("arst_valid", valid_d, 1'b0);
    chk("arst_instr", instr_d, 32'h0);
    chk("arst_pcd",   pc_d, 32'h0);
    chk("arst_step",  pc_step_d, 32'h0);
    chk("arst_halt",  halted, 1'b0);
    chk("arst_count", fetch_count, 16'h0);
    edge_step();
    reset = 1'b1;
    edge_step();
    chk("arst_boot_valid", valid_d, 1'b0);
    chk("arst_boot_addr",  imem_addr, 32'h0);
    edge_step();
    chk("arst_run_valid", valid_d, 1'b1);
    chk("arst_run_instr", instr_d, 32'h1000);
    chk("arst_run_addr",  imem_addr, 32'h4);

    // Randomized run against the model.
    reset = 1'b0;
    edge_step();
    reset = 1'b1;
    m_mode = 0; m_pc = 0; m_clear(); m_count = 0;
    for (int n = 0; n < 3000; n++) begin
      stall_f       = ($urandom_range(0, 3) == 0);
      flush_d       = ($urandom_range(0, 7) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      branch_target = $urandom_range(0, 15) * 4;
      model_edge(stall_f, flush_d, branch_taken, branch_target);
      edge_step();
      chk("rnd_pc",    imem_addr, m_pc);
      chk("rnd_valid", valid_d, m_valid);
      chk("rnd_instr", instr_d, m_instr);
      chk("rnd_pcd",   pc_d, m_pcd);
      chk("rnd_step",  pc_step_d, m_step);
      chk("rnd_halt",  halted, (m_mode == 2));
      chk("rnd_count", fetch_count, m_count[15:0]);
    end
    stall_f = 1'b0; flush_d = 1'b0; branch_taken = 1'b0;

    // 8-bit PC wrap, then issue-counter saturation.
    br8 = 1'b1; tgt8 = 8'hFC;
    edge_step();
    chk("wrap_addr0", {24'h0, a8}, 32'hFC);
    br8 = 1'b0;
    edge_step();
    chk("wrap_pcd",   {24'h0, pcd8}, 32'hFC);
    chk("wrap_step",  {24'h0, step8}, 32'h00);
    chk("wrap_addr1", {24'h0, a8}, 32'h00);
    chk("wrap_valid", valid8, 1'b1);
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_count", count8, 16'hFFFF);
    repeat (3) edge_step();
    chk("sat_hold", count8, 16'hFFFF);
    chk("sat_valid", valid8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Fetch stage of the pipelined core; sits directly upstream of the decode pipeline register.
- Owns the program counter, drives the instruction-memory address, and loads the fetch/decode register (instruction, PC, PC+step, valid).
- Handles stall, decode flush and branch redirect from the hazard unit.
- Runs a small BOOT/RUN/HALT sequencer and a saturating issued-instruction counter.

Parameters:
- WIDTH, 32, address/PC width in bits.
- INSTR_W, 32, instruction width in bits.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, PC increment per issued instruction.
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that halts fetch.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- imem_addr  out  WIDTH  instruction memory address; combinational copy of pc_f.
- imem_rdata  in  INSTR_W  instruction memory data; combinational, valid in the same cycle as imem_addr.
- stall_f  in  1  hold PC and decode register.
- flush_d  in  1  clear the decode register to a bubble.
- branch_taken  in  1  redirect the PC.
- branch_target  in  WIDTH  redirect address.
- instr_d  out  INSTR_W  decode-stage instruction.
- pc_d  out  WIDTH  PC of instr_d.
- pc_step_d  out  WIDTH  pc_d + PC_STEP.
- valid_d  out  1  instr_d is a real instruction.
- halted  out  1  sequencer is in HALT.
- fetch_count  out  16  count of issued instructions, saturating.

Behaviour:
- Reset is asynchronous: it acts immediately on reset=0, without waiting for a clock edge.
- Reset values:
  - pc_f = RESET_PC; state = BOOT.
  - instr_d = 0, pc_d = 0, pc_step_d = 0, valid_d = 0.
  - halted = 0, fetch_count = 0.
- All other updates happen on the rising clk edge.
- Reset asserted mid-operation aborts everything and returns every output to its reset value at once.
- Issue event: decode register loads {imem_rdata, pc_f, pc_f + PC_STEP} with valid_d = 1.
- Latency: instruction at pc_f appears on instr_d 1 cycle after issue.
- PC arithmetic is modulo 2^WIDTH; pc_f + PC_STEP wraps silently.
- State BOOT:
  - Lasts exactly 1 cycle after reset release.
  - PC holds; no issue; valid_d stays 0.
  - Next state: RUN, unconditionally. All inputs are ignored in this cycle.
- State RUN, priority order:
  1. branch_taken: pc_f <= branch_target; decode register cleared (instr_d = 0, valid_d = 0; pc_d and pc_step_d also cleared). Overrides stall_f and flush_d. No issue.
  2. stall_f: pc_f holds. Decode register holds, except that flush_d=1 clears it. No issue.
  3. Otherwise: issue.
     - If imem_rdata == HALT_WORD: the halt word is issued, pc_f holds, state <= HALT.
     - Else: pc_f <= pc_f + PC_STEP.
     - If flush_d=1 in the same cycle, the decode register is cleared instead of loaded, and no issue is counted. The PC still advances; the hazard unit guarantees that combination is intended.
- State HALT:
  - halted = 1.
  - pc_f holds.
  - Decode register: holds if stall_f=1; is cleared if flush_d=1; otherwise takes a bubble (valid_d = 0).
  - branch_taken=1: pc_f <= branch_target, decode register cleared, state <= RUN. halted drops the next cycle, and issue resumes that cycle.
  - Only branch_taken or reset leaves HALT.
- fetch_count:
  - +1 on each issue event (valid load with valid_d = 1).
  - Saturates at 16'hFFFF.
  - Never decrements.
- stall_f and branch_taken asserted together: the branch wins. The stall does not delay the redirect.
- branch_target is used unmodified; alignment is not checked.

Test Plan:
1. Reset, then sequential fetch. Hold reset=0 for 2 cycles, then release. Memory returns 0x1000+addr.
   - imem_addr = 0 during BOOT and the first RUN cycle.
   - valid_d first rises 2 edges after release, with instr_d = 0x1000, pc_d = 0, pc_step_d = 4.
   - Next edge: pc_d = 4; fetch_count = 2.
2. Stall and flush. Assert stall_f for 3 cycles while pc_f = 8.
   - imem_addr stays 8 and instr_d/pc_d hold; fetch_count is unchanged.
   - Assert flush_d together with stall_f for 1 cycle: valid_d = 0 and instr_d = 0, with pc_f still 8.
3. Branch versus stall. With pc_f = 0x10, assert branch_taken=1, branch_target = 0x40 and stall_f=1 together.
   - Next edge: imem_addr = 0x40, valid_d = 0.
   - With no stall, the following edge gives pc_d = 0x40.
4. Halt and resume. Memory returns 0xFFFFFFFF at 0x20.
   - instr_d = 0xFFFFFFFF and valid_d = 1, and pc_f stays 0x20; halted = 1 on that same edge.
   - Subsequent cycles: valid_d = 0 and fetch_count frozen.
   - branch_taken with target 0x80: halted = 0 and imem_addr = 0x80.
5. Wrap and saturation. Drive WIDTH=8 and branch to 0xFC.
   - Issued pc_step_d = 0x00; next imem_addr = 0x00.
   - Separately, preload or run 65540 issues: fetch_count stays 0xFFFF.
6. Asynchronous reset mid-run. Drop reset=0 between clock edges while valid_d = 1 and halted = 0.
   - All outputs return to their reset values before the next edge.
   - After release, BOOT lasts exactly 1 cycle.
